// File: rtl/parity_serial_tx_pkg.sv
// Shared definitions for the parity serial transmitter: FSM encodings and
// frame/counter sizing helpers.
package parity_serial_tx_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } tx_state_e;

   // Clock cycles from the start bit through the last stop cycle.
   function automatic int unsigned frame_len(input int unsigned data_w,
                                             input int unsigned clks_per_bit);
      return (data_w + 3) * clks_per_bit;
   endfunction

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/parity_serial_tx_if.sv
// Producer-side handshake and serial line status of the parity transmitter.
interface parity_serial_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              tx_out;
   logic              tx_busy;
   logic              tx_done;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx_out, tx_busy, tx_done
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx_out, tx_busy, tx_done
   );
endinterface

// File: rtl/parity_serial_tx_baud_tick_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module baud_tick_counter
   import parity_serial_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic bit_tick
);
   localparam int CW = cnt_w(CLKS_PER_BIT);
   localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign bit_tick = (cnt == TERM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || bit_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start(0), data LSB-first, parity, stop(1), with a
// valid/ready word interface and registered line output.
module parity_serial_tx
   import parity_serial_tx_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   parity_serial_tx_if.slave bus
);
   localparam int BW = cnt_w(DATA_W);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   tx_state_e         state;
   tx_state_e         state_nxt;
   logic [BW-1:0]     bit_idx;
   logic [BW-1:0]     bit_idx_nxt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nxt;
   logic              par_bit;
   logic              tx_out_r;
   logic              tx_out_nxt;
   logic              bit_tick;
   logic              baud_clear;
   logic              bit_last;
   logic              last_stop;
   logic              xfer;

   function automatic logic calc_parity(input logic [DATA_W-1:0] d);
      return PARITY_ODD ? ~^d : ^d;
   endfunction

   assign baud_clear = (state == IDLE);

   baud_tick_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (baud_clear),
      .bit_tick (bit_tick)
   );

   assign bit_last  = (bit_idx == LAST_BIT);
   assign last_stop = (state == STOP) && bit_tick;

   // Ready is held low while reset is asserted, even though the FSM sits in IDLE.
   assign bus.tx_ready = rst_n & ((state == IDLE) | last_stop);
   assign xfer         = bus.tx_valid & bus.tx_ready;
   assign bus.tx_busy  = (state != IDLE);
   assign bus.tx_done  = last_stop;
   assign bus.tx_out   = tx_out_r;

   always_comb begin
      state_nxt   = state;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      tx_out_nxt  = 1'b1;

      case (state)
         IDLE:   if (xfer) state_nxt = START;
         START:  if (bit_tick) state_nxt = DATA;
         DATA: begin
            if (bit_tick) begin
               if (bit_last) begin
                  state_nxt   = PARITY;
                  bit_idx_nxt = '0;
               end else begin
                  bit_idx_nxt = bit_idx + 1'b1;
                  shreg_nxt   = shreg >> 1;
               end
            end
         end
         PARITY: if (bit_tick) state_nxt = STOP;
         STOP:   if (bit_tick) state_nxt = xfer ? START : IDLE;
         default: state_nxt = IDLE;
      endcase

      if (xfer) shreg_nxt = bus.tx_data;

      // The line register is loaded with the bit belonging to the upcoming state,
      // so tx_out lines up exactly with the state it represents.
      case (state_nxt)
         START:   tx_out_nxt = 1'b0;
         DATA:    tx_out_nxt = shreg_nxt[0];
         PARITY:  tx_out_nxt = par_bit;
         default: tx_out_nxt = 1'b1;
      endcase
   end

   // Control state and line output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bit_idx  <= '0;
         tx_out_r <= 1'b1;
      end else begin
         state    <= state_nxt;
         bit_idx  <= bit_idx_nxt;
         tx_out_r <= tx_out_nxt;
      end
   end

   // Data path: word and parity captured on transfer, no reset needed
   always_ff @(posedge clk) begin
      shreg <= shreg_nxt;
      if (xfer) par_bit <= calc_parity(bus.tx_data);
   end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: even/odd parity, back-to-back frames,
// mid-frame reset and single-cycle bit period.
module tb_parity_serial_tx;
   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] data_r [3];
   logic [2:0] valid_r;
   logic [2:0] line_w, ready_w, busy_w, done_w;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   parity_serial_tx_if #(.DATA_W(8)) bus_e ();
   parity_serial_tx_if #(.DATA_W(8)) bus_o ();
   parity_serial_tx_if #(.DATA_W(8)) bus_f ();

   assign bus_e.tx_data  = data_r[0];
   assign bus_e.tx_valid = valid_r[0];
   assign bus_o.tx_data  = data_r[1];
   assign bus_o.tx_valid = valid_r[1];
   assign bus_f.tx_data  = data_r[2];
   assign bus_f.tx_valid = valid_r[2];

   assign line_w  = {bus_f.tx_out,   bus_o.tx_out,   bus_e.tx_out};
   assign ready_w = {bus_f.tx_ready, bus_o.tx_ready, bus_e.tx_ready};
   assign busy_w  = {bus_f.tx_busy,  bus_o.tx_busy,  bus_e.tx_busy};
   assign done_w  = {bus_f.tx_done,  bus_o.tx_done,  bus_e.tx_done};

   parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut_e (
      .clk(clk), .rst_n(rst_n), .bus(bus_e));
   parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut_o (
      .clk(clk), .rst_n(rst_n), .bus(bus_o));
   parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut_f (
      .clk(clk), .rst_n(rst_n), .bus(bus_f));

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One frame on instance sel; par is the hand-computed parity bit.
   task automatic send(input int sel, input logic [7:0] d, input int cpb,
                       input logic par, input string tag);
      logic [10:0] fr;
      int          n;
      fr = {1'b1, par, d, 1'b0};
      n  = 11 * cpb;
      @(negedge clk);
      data_r[sel]  = d;
      valid_r[sel] = 1'b1;
      chk({tag, " ready_idle"}, ready_w[sel], 1'b1);
      @(posedge clk);
      #1;
      valid_r[sel] = 1'b0;
      data_r[sel]  = ~d;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         chk($sformatf("%s line c%0d", tag, k), line_w[sel], fr[(k - 1) / cpb]);
         chk($sformatf("%s busy c%0d", tag, k), busy_w[sel], 1'b1);
         chk($sformatf("%s done c%0d", tag, k), done_w[sel], k == n);
         chk($sformatf("%s ready c%0d", tag, k), ready_w[sel], k == n);
      end
      @(negedge clk);
      chk({tag, " line_after"}, line_w[sel], 1'b1);
      chk({tag, " busy_after"}, busy_w[sel], 1'b0);
      chk({tag, " ready_after"}, ready_w[sel], 1'b1);
   endtask

   initial begin
      logic [10:0] fr1;
      logic [10:0] fr2;
      logic        exp_bit;
      for (int i = 0; i < 3; i++) data_r[i] = 8'h00;
      valid_r = 3'b000;
      #1 rst_n = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("rst line%0d", s), line_w[s], 1'b1);
         chk($sformatf("rst busy%0d", s), busy_w[s], 1'b0);
         chk($sformatf("rst done%0d", s), done_w[s], 1'b0);
         chk($sformatf("rst ready%0d", s), ready_w[s], 1'b0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk($sformatf("idle line c%0d", k), line_w[0], 1'b1);
      end
      for (int s = 0; s < 3; s++) chk($sformatf("idle ready%0d", s), ready_w[s], 1'b1);

      // Even and odd parity frames (A5: 4 ones, 07: 3 ones)
      send(0, 8'hA5, 4, 1'b0, "a5_even");
      send(1, 8'h07, 4, 1'b0, "07_odd");
      send(0, 8'h07, 4, 1'b1, "07_even");

      // Back-to-back 00 then FF with valid held high
      fr1 = {1'b1, 1'b0, 8'h00, 1'b0};
      fr2 = {1'b1, 1'b0, 8'hFF, 1'b0};
      @(negedge clk);
      data_r[0]  = 8'h00;
      valid_r[0] = 1'b1;
      @(posedge clk);
      #1 data_r[0] = 8'hFF;
      for (int k = 1; k <= 88; k++) begin
         @(negedge clk);
         exp_bit = (k <= 44) ? fr1[(k - 1) / 4] : fr2[(k - 45) / 4];
         chk($sformatf("b2b line c%0d", k), line_w[0], exp_bit);
         chk($sformatf("b2b busy c%0d", k), busy_w[0], 1'b1);
         chk($sformatf("b2b done c%0d", k), done_w[0], (k == 44) || (k == 88));
         if (k == 44) begin
            @(posedge clk);
            #1 valid_r[0] = 1'b0;
         end
      end
      @(negedge clk);
      chk("b2b line_after", line_w[0], 1'b1);
      chk("b2b busy_after", busy_w[0], 1'b0);

      // Reset during data bit 3 of 3C (bit 3 = 1, bits 6/7 = 0 would show later)
      @(negedge clk);
      data_r[0]  = 8'h3C;
      valid_r[0] = 1'b1;
      @(posedge clk);
      #1 valid_r[0] = 1'b0;
      repeat (18) @(negedge clk);
      chk("abort pre line_bit3", line_w[0], 1'b1);
      chk("abort pre busy", busy_w[0], 1'b1);
      rst_n = 1'b0;
      #1;
      chk("abort line", line_w[0], 1'b1);
      chk("abort busy", busy_w[0], 1'b0);
      chk("abort done", done_w[0], 1'b0);
      chk("abort ready", ready_w[0], 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         chk($sformatf("abort idle line c%0d", k), line_w[0], 1'b1);
         chk($sformatf("abort idle done c%0d", k), done_w[0], 1'b0);
      end
      send(0, 8'h81, 4, 1'b0, "81_after_rst");

      // Single-cycle bit period, data changed right after transfer
      send(2, 8'h5A, 1, 1'b0, "5a_cpb1");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
